iq_fir_sched: RTL and testbench

Time-multiplexing scheduler that shares one symmetric-FIR MAC datapath (5 tap-pair products per output, tap-pair select 0..4) between the I and Q channels of the IQ demodulator. It latches per-channel sample strobes, arbitrates round-robin, issues 5-cycle MAC bursts with accumulator control, and emits per-channel result strobes aligned to the MAC pipeline latency. It also flags sample overruns. It sits between the decimator sample strobes and the shared MAC/accumulator.

---
 rtl/iq_fir_sched.sv | 145 ++++++++++++++
 tb/tb_iq_fir_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_fir_sched.sv
// iq_fir_sched: shares one symmetric-FIR MAC between the I and Q channels.
// Define SCHED_OVR_CNT_EN to add saturating per-channel overrun counters.
module iq_fir_sched #(
  parameter int NTAP_PAIRS = 5,
  parameter int MAC_LAT    = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       i_valid,
  input  logic       q_valid,
  input  logic       clr_ovr,
  output logic       mac_en,
  output logic       mac_ch,
  output logic [2:0] mac_sel,
  output logic       mac_first,
  output logic       mac_last,
  output logic       i_out_valid,
  output logic       q_out_valid,
  output logic       busy,
  output logic       ovr_i,
  output logic       ovr_q,
  output logic [7:0] ovr_cnt_i,
  output logic [7:0] ovr_cnt_q
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] LAST = 3'(NTAP_PAIRS - 1);

  state_t             state;
  logic [2:0]         cnt;
  logic               pend_i;
  logic               pend_q;
  logic               rr_last;
  logic [MAC_LAT-1:0] p_last;
  logic [MAC_LAT-1:0] p_ch;

  logic free;
  logic elig_i;
  logic elig_q;
  logic gnt_i;
  logic gnt_q;
  logic ovr_ev_i;
  logic ovr_ev_q;

  // A sample strobed this cycle is still settling into its delay line.
  assign free   = (state == IDLE) | (cnt == LAST);
  assign elig_i = pend_i & ~i_valid;
  assign elig_q = pend_q & ~q_valid;
  assign gnt_i  = enable & free & elig_i & (~elig_q | rr_last);
  assign gnt_q  = enable & free & elig_q & (~elig_i | ~rr_last);

  assign ovr_ev_i = i_valid & ((pend_i & ~gnt_i) |
                    ((state == RUN) & ~mac_ch));
  assign ovr_ev_q = q_valid & ((pend_q & ~gnt_q) |
                    ((state == RUN) & mac_ch));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_last   <= 1'b1;
      mac_en    <= 1'b0;
      mac_ch    <= 1'b0;
      mac_sel   <= '0;
      mac_first <= 1'b0;
      mac_last  <= 1'b0;
    end else if (gnt_i | gnt_q) begin
      state     <= RUN;
      cnt       <= '0;
      rr_last   <= gnt_q;
      mac_en    <= 1'b1;
      mac_ch    <= gnt_q;
      mac_sel   <= '0;
      mac_first <= 1'b1;
      mac_last  <= 1'b0;
    end else if (state == RUN && cnt != LAST) begin
      cnt       <= cnt + 3'd1;
      mac_sel   <= cnt + 3'd1;
      mac_first <= 1'b0;
      mac_last  <= (cnt + 3'd1 == LAST);
    end else begin
      state     <= IDLE;
      mac_en    <= 1'b0;
      mac_first <= 1'b0;
      mac_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_i <= 1'b0;
      pend_q <= 1'b0;
      ovr_i  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      pend_i <= (pend_i & ~gnt_i) | i_valid;
      pend_q <= (pend_q & ~gnt_q) | q_valid;
      ovr_i  <= ovr_ev_i | (ovr_i & ~clr_ovr);
      ovr_q  <= ovr_ev_q | (ovr_q & ~clr_ovr);
    end
  end

  // Result pipe mirrors the MAC latency; its tail drives the strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_last <= '0;
      p_ch   <= '0;
    end else begin
      p_last[0] <= mac_last;
      p_ch[0]   <= mac_ch;
      for (int k = 1; k < MAC_LAT; k++) begin
        p_last[k] <= p_last[k-1];
        p_ch[k]   <= p_ch[k-1];
      end
    end
  end

  assign i_out_valid = p_last[MAC_LAT-1] & ~p_ch[MAC_LAT-1];
  assign q_out_valid = p_last[MAC_LAT-1] & p_ch[MAC_LAT-1];
  assign busy        = mac_en | (|p_last);

`ifdef SCHED_OVR_CNT_EN
  logic [7:0] cnt_i;
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_i <= '0;
      cnt_q <= '0;
    end else begin
      if (ovr_ev_i && cnt_i != 8'hff) cnt_i <= cnt_i + 8'd1;
      if (ovr_ev_q && cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign ovr_cnt_i = cnt_i;
  assign ovr_cnt_q = cnt_q;
`else
  assign ovr_cnt_i = 8'd0;
  assign ovr_cnt_q = 8'd0;
`endif

endmodule

// File: tb/tb_iq_fir_sched.sv
// tb_iq_fir_sched: directed and random checks of iq_fir_sched against a
// burst-timeline reference model.
module tb_iq_fir_sched;

  localparam int N   = 5;
  localparam int LAT = 2;
`ifdef SCHED_OVR_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       i_valid = 1'b0;
  logic       q_valid = 1'b0;
  logic       clr_ovr = 1'b0;
  logic       mac_en, mac_ch, mac_first, mac_last;
  logic       i_out_valid, q_out_valid, busy, ovr_i, ovr_q;
  logic [2:0] mac_sel;
  logic [7:0] ovr_cnt_i, ovr_cnt_q;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int s_cyc;

  iq_fir_sched #(.NTAP_PAIRS(N), .MAC_LAT(LAT)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .i_valid(i_valid), .q_valid(q_valid), .clr_ovr(clr_ovr),
    .mac_en(mac_en), .mac_ch(mac_ch), .mac_sel(mac_sel),
    .mac_first(mac_first), .mac_last(mac_last),
    .i_out_valid(i_out_valid), .q_out_valid(q_out_valid),
    .busy(busy), .ovr_i(ovr_i), .ovr_q(ovr_q),
    .ovr_cnt_i(ovr_cnt_i), .ovr_cnt_q(ovr_cnt_q)
  );

  always #5 clk = ~clk;

  // Model: a burst granted at cycle g occupies g+1..g+N, result at g+N+LAT.
  int  m_t, m_bs, m_bch, m_sel, m_rr, m_ci, m_cq;
  bit  m_pi, m_pq, m_oi, m_oq;
  int  sq_t[$];
  bit  sq_c[$];

  logic [28:0] a_vec, e_vec;
  logic        a_first, a_ch, a_iout, a_qout, a_ovr_i;

  task automatic m_reset();
    m_t = 0; m_bs = -100; m_bch = 0; m_sel = 0; m_rr = 1;
    m_ci = 0; m_cq = 0; m_pi = 0; m_pq = 0; m_oi = 0; m_oq = 0;
    sq_t.delete(); sq_c.delete();
  endtask

  task automatic do_reset();
    i_valid = 0; q_valid = 0; clr_ovr = 0; enable = 0;
    resetn = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    m_reset();
    cyc = 0;
  endtask

  task automatic tick(input bit iv, input bit qv, input bit en, input bit clr);
    bit act, oi, oq, bz, gi, gq, ei, eq, ov_i, ov_q;
    i_valid = iv; q_valid = qv; enable = en; clr_ovr = clr;
    #4;
    act = (m_t >= m_bs) && (m_t < m_bs + N);
    if (act) m_sel = m_t - m_bs;
    oi = 0; oq = 0;
    bz = act || (sq_t.size() > 0);
    foreach (sq_t[k]) if (sq_t[k] == m_t) begin
      if (sq_c[k]) oq = 1; else oi = 1;
    end
    e_vec = {act, m_bch[0], 3'(m_sel), act && m_t == m_bs,
             act && m_t == m_bs + N - 1, oi, oq, bz, m_oi, m_oq,
             8'(m_ci), 8'(m_cq)};
    a_vec = {mac_en, mac_ch, mac_sel, mac_first, mac_last,
             i_out_valid, q_out_valid, busy, ovr_i, ovr_q,
             ovr_cnt_i, ovr_cnt_q};
    a_first = mac_first; a_ch = mac_ch; a_ovr_i = ovr_i;
    a_iout = i_out_valid; a_qout = q_out_valid;
    s_cyc = cyc;
    gi = 0; gq = 0;
    if (en && (!act || m_t == m_bs + N - 1)) begin
      ei = m_pi && !iv;
      eq = m_pq && !qv;
      if (ei && eq) begin
        if (m_rr == 1) gi = 1; else gq = 1;
      end else begin
        gi = ei; gq = eq;
      end
    end
    ov_i = iv && ((m_pi && !gi) || (act && m_bch == 0));
    ov_q = qv && ((m_pq && !gq) || (act && m_bch == 1));
    if (gi || gq) begin
      m_bs = m_t + 1; m_bch = gq ? 1 : 0; m_rr = m_bch;
      sq_t.push_back(m_t + N + LAT); sq_c.push_back(gq);
    end
    m_pi = (m_pi && !gi) || iv;
    m_pq = (m_pq && !gq) || qv;
    m_oi = ov_i || (m_oi && !clr);
    m_oq = ov_q || (m_oq && !clr);
    if (CNT_ON == 1) begin
      if (ov_i && m_ci < 255) m_ci++;
      if (ov_q && m_cq < 255) m_cq++;
    end
    @(posedge clk);
    #1;
    m_t++; cyc++;
    while (sq_t.size() > 0 && sq_t[0] < m_t) begin
      void'(sq_t.pop_front());
      void'(sq_c.pop_front());
    end
  endtask

  task automatic test_reset();
    resetn = 0; enable = 1; i_valid = 1; q_valid = 1;
    repeat (2) @(posedge clk);
    #2;
    nchk++;
    if ({mac_en, mac_ch, mac_sel, mac_first, mac_last, i_out_valid,
         q_out_valid, busy, ovr_i, ovr_q, ovr_cnt_i, ovr_cnt_q} !== 29'd0) begin
      nfail++;
      $display("FAIL reset_outs: got %h want 0", {mac_en, mac_ch, mac_sel,
        mac_first, mac_last, i_out_valid, q_out_valid, busy});
    end
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick(0, 0, 1, 0);
      nchk++;
      if (a_vec !== e_vec) begin
        nfail++;
        $display("FAIL reset_idle cyc %0d: got %h want %h", s_cyc, a_vec, e_vec);
      end
    end
  endtask

  task automatic test_single_i();
    int fq[$]; int oq[$]; int sq[$];
    do_reset();
    while (cyc < 25) begin
      tick(cyc == 10, 0, 1, 0);
      nchk++;
      if (a_vec !== e_vec) begin
        nfail++;
        $display("FAIL single_vec cyc %0d: got %h want %h", s_cyc, a_vec, e_vec);
      end
      if (a_first) fq.push_back(s_cyc);
      if (a_iout) oq.push_back(s_cyc);
      if (mac_en && s_cyc >= 12) sq.push_back(int'(mac_sel));
    end
    nchk++;
    if (fq.size() != 1 || fq[0] != 12) begin
      nfail++;
      $display("FAIL single_first: got %p want '{12}", fq);
    end
    nchk++;
    if (oq.size() != 1 || oq[0] != 18) begin
      nfail++;
      $display("FAIL single_out: got %p want '{18}", oq);
    end
  endtask

  task automatic test_simul_rr();
    int fq[$]; int fc[$]; int oi[$]; int oq[$];
    do_reset();
    while (cyc < 95) begin
      tick(cyc == 10 || cyc == 32 || cyc == 52 || cyc == 72,
           cyc == 10 || cyc == 32 || cyc == 72, 1, 0);
      nchk++;
      if (a_vec !== e_vec) begin
        nfail++;
        $display("FAIL rr_vec cyc %0d: got %h want %h", s_cyc, a_vec, e_vec);
      end
      if (a_first) begin fq.push_back(s_cyc); fc.push_back(int'(a_ch)); end
      if (a_iout) oi.push_back(s_cyc);
      if (a_qout) oq.push_back(s_cyc);
    end
    nchk++;
    if (fq.size() != 7 || fq[0] != 12 || fq[1] != 17 ||
        fc[0] != 0 || fc[1] != 1) begin
      nfail++;
      $display("FAIL simul_bursts: got %p ch %p want 12,17 ch 0,1", fq, fc);
    end
    nchk++;
    if (oi.size() < 1 || oi[0] != 18 || oq.size() < 1 || oq[0] != 23) begin
      nfail++;
      $display("FAIL simul_out: got i %p q %p want 18 / 23", oi, oq);
    end
    nchk++;
    if (fc.size() != 7 || fc[2] != 0 || fc[3] != 1 || fc[4] != 0 ||
        fc[5] != 1 || fc[6] != 0 || fq[2] != 34 || fq[5] != 74) begin
      nfail++;
      $display("FAIL rr_order: got %p at %p want ch 0,1,0,1,0", fc, fq);
    end
  endtask

  task automatic test_overrun();
    int fq[$]; int oq[$]; int o13, o14, o26;
    do_reset();
    o13 = -1; o14 = -1; o26 = -1;
    while (cyc < 30) begin
      tick(cyc == 10 || cyc == 13, 0, 1, cyc == 25);
      nchk++;
      if (a_vec !== e_vec) begin
        nfail++;
        $display("FAIL ovr_vec cyc %0d: got %h want %h", s_cyc, a_vec, e_vec);
      end
      if (a_first) fq.push_back(s_cyc);
      if (a_iout) oq.push_back(s_cyc);
      if (s_cyc == 13) o13 = int'(a_ovr_i);
      if (s_cyc == 14) o14 = int'(a_ovr_i);
      if (s_cyc == 26) o26 = int'(a_ovr_i);
    end
    nchk++;
    if (o13 != 0 || o14 != 1 || o26 != 0) begin
      nfail++;
      $display("FAIL ovr_flag: got %0d,%0d,%0d want 0,1,0", o13, o14, o26);
    end
    nchk++;
    if (fq.size() != 2 || fq[1] != 17 || oq.size() != 2 ||
        oq[0] != 18 || oq[1] != 23) begin
      nfail++;
      $display("FAIL ovr_bursts: got %p out %p want 12,17 out 18,23", fq, oq);
    end
    nchk++;
    if (ovr_cnt_i !== 8'(CNT_ON)) begin
      nfail++;
      $display("FAIL ovr_cnt1: got %0d want %0d", ovr_cnt_i, CNT_ON);
    end
    for (int c = 0; c < 300; c++) tick(1, 0, 1, 0);
    tick(0, 0, 1, 0);
    nchk++;
    if (a_vec !== e_vec) begin
      nfail++;
      $display("FAIL ovr_sat_vec: got %h want %h", a_vec, e_vec);
    end
    nchk++;
    if (ovr_cnt_i !== 8'(CNT_ON * 255)) begin
      nfail++;
      $display("FAIL ovr_sat: got %0d want %0d", ovr_cnt_i, CNT_ON * 255);
    end
  endtask

  task automatic test_enable_low();
    int fq[$]; int fc[$];
    do_reset();
    while (cyc < 45) begin
      tick(cyc == 15, cyc == 10, cyc < 14 || cyc >= 30, 0);
      nchk++;
      if (a_vec !== e_vec) begin
        nfail++;
        $display("FAIL en_vec cyc %0d: got %h want %h", s_cyc, a_vec, e_vec);
      end
      if (a_first) begin fq.push_back(s_cyc); fc.push_back(int'(a_ch)); end
    end
    nchk++;
    if (fq.size() != 2 || fq[0] != 12 || fc[0] != 1 ||
        fq[1] != 31 || fc[1] != 0) begin
      nfail++;
      $display("FAIL en_bursts: got %p ch %p want 12,31 ch 1,0", fq, fc);
    end
  endtask

  task automatic test_reset_mid_burst();
    int fq[$]; int oq[$];
    do_reset();
    while (cyc < 14) tick(cyc == 10, 0, 1, 0);
    resetn = 0;
    #1;
    nchk++;
    if ({mac_en, mac_ch, mac_sel, mac_first, mac_last, i_out_valid,
         q_out_valid, busy, ovr_i, ovr_q} !== 13'd0) begin
      nfail++;
      $display("FAIL midrst_outs: got %h want 0", {mac_en, mac_sel, busy});
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    m_reset();
    cyc = 0;
    while (cyc < 25) begin
      tick(cyc == 5, 0, 1, 0);
      nchk++;
      if (a_vec !== e_vec) begin
        nfail++;
        $display("FAIL midrst_vec cyc %0d: got %h want %h", s_cyc, a_vec, e_vec);
      end
      if (a_first) fq.push_back(s_cyc);
      if (a_iout) oq.push_back(s_cyc);
    end
    nchk++;
    if (fq.size() != 1 || fq[0] != 7 || oq.size() != 1 || oq[0] != 13) begin
      nfail++;
      $display("FAIL midrst_lat: got %p out %p want 7 out 13", fq, oq);
    end
  endtask

  task automatic test_random();
    bit iv, qv, en, clr;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      iv  = ($urandom_range(0, 11) == 0);
      qv  = ($urandom_range(0, 11) == 0);
      en  = ($urandom_range(0, 15) != 0);
      clr = ($urandom_range(0, 19) == 0);
      tick(iv, qv, en, clr);
      nchk++;
      if (a_vec !== e_vec) begin
        nfail++;
        $display("FAIL rand_vec cyc %0d: got %h want %h", s_cyc, a_vec, e_vec);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single_i();
    test_simul_rr();
    test_overrun();
    test_enable_low();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
